// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared constants and state encoding for the SPI master controller
//
// Purpose: opcode values, word widths, frame-phase terminal counts and FSM
//          state encoding used by spi_master_ctrl and spi_master_shifter.
// Ports:   none (package).
package spi_pkg;

  localparam int CMD_W  = 10;
  localparam int DATA_W = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  // Terminal values of the shared phase counter.
  localparam logic [3:0] SHIFT_LAST = 4'(CMD_W - 1);
  localparam logic [3:0] RECV_LAST  = 4'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEL,
    SHIFT,
    GUARD,
    WAIT_RD,
    RECV,
    STOP
  } state_t;

endpackage

// File: rtl/spi_master_shifter.sv
// rtl/spi_master_shifter.sv - MOSI parallel-in/serial-out and MISO serial-in/parallel-out
//
// Purpose: holds the command word and presents its MSB for MOSI; collects MISO
//          bits MSB first. All enables come from the controller FSM.
// Ports:   clk, rst         clock and synchronous active-high reset
//          load, load_data  capture a new command word
//          shift_en         advance the command word by one bit
//          capture_en       shift the current MISO bit into the receive register
//          miso             serial input
//          mosi_bit         current MSB of the command register
//          rx_next          receive register with the current MISO bit appended
module spi_master_shifter
  import spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CMD_W-1:0]  load_data,
  input  logic              shift_en,
  input  logic              capture_en,
  input  logic              miso,
  output logic              mosi_bit,
  output logic [DATA_W-1:0] rx_next
);

  logic [CMD_W-1:0]  piso;
  logic [DATA_W-1:0] sipo;

  always_ff @(posedge clk) begin
    if (rst) begin
      piso <= '0;
      sipo <= '0;
    end else begin
      if (load) begin
        piso <= load_data;
      end else if (shift_en) begin
        piso <= {piso[CMD_W-2:0], 1'b0};
      end
      if (capture_en) begin
        sipo <= rx_next;
      end
    end
  end

  assign mosi_bit = piso[CMD_W-1];
  // Exposed so the controller can latch the full byte on the last RECV edge.
  assign rx_next  = {sipo[DATA_W-2:0], miso};

endmodule

// File: rtl/spi_master_ctrl.sv
// rtl/spi_master_ctrl.sv - host-side SPI master framing 10-bit commands onto MOSI/MISO
//
// Purpose: accepts a command word, drives one SS_n frame (START, SEL, 10 SHIFT
//          bits, GUARD), and for read-data commands waits RD_LAT cycles and
//          samples 8 MISO bits into rd_data.
// Ports:   clk, rst                      clock, synchronous active-high reset
//          cmd_valid, cmd_ready, cmd_data command handshake, [9:8] opcode, [7:0] payload
//          SS_n, MOSI, MISO              serial interface (SS_n/MOSI registered)
//          rd_valid, rd_data             read byte and its 1-cycle strobe
//          cmd_done                      1-cycle pulse as SS_n returns high
//          cmd_err                       only with SPI_MASTER_SEQ_CHECK_EN: rd-data
//                                        rejected because no rd-addr preceded it
// Config:  SPI_MASTER_SEQ_CHECK_EN enables rd-addr/rd-data sequence checking.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LAT   = 4,
  parameter int IDLE_GAP = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CMD_W-1:0]  cmd_data,
  output logic              SS_n,
  output logic              MOSI,
  input  logic              MISO,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              cmd_done
`ifdef SPI_MASTER_SEQ_CHECK_EN
  ,
  output logic              cmd_err
`endif
);

  localparam logic [3:0] WAIT_LAST = 4'(RD_LAT - 1);
  localparam logic [3:0] GAP_MIN   = 4'(IDLE_GAP);

  state_t            state;
  logic [3:0]        cnt;
  logic [3:0]        gap_cnt;
  logic [1:0]        opcode;
  logic              accept;
  logic              gap_met;
  logic              seq_block;
  logic              sh_shift;
  logic              sh_capture;
  logic              sh_bit;
  logic [DATA_W-1:0] rx_next;

  assign accept     = (state == IDLE) && cmd_ready && cmd_valid;
  // gap_cnt counts cycles SS_n has been high, including the current one.
  assign gap_met    = (gap_cnt >= GAP_MIN);
  // SEL shows cmd[9] and SHIFT re-sends it, so the register starts moving on the SEL edge.
  assign sh_shift   = (state == SEL) || ((state == SHIFT) && (cnt != SHIFT_LAST));
  assign sh_capture = (state == RECV);

`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic rd_addr_seen;
  assign seq_block = (cmd_data[CMD_W-1:CMD_W-2] == OP_RD_DATA) && !rd_addr_seen;
`else
  assign seq_block = 1'b0;
`endif

  spi_master_shifter u_shifter (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_data  (cmd_data),
    .shift_en   (sh_shift),
    .capture_en (sh_capture),
    .miso       (MISO),
    .mosi_bit   (sh_bit),
    .rx_next    (rx_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      cmd_ready <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      cmd_done  <= 1'b0;
      cnt       <= '0;
      gap_cnt   <= 4'd1;
      opcode    <= OP_WR_ADDR;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      cmd_err      <= 1'b0;
      rd_addr_seen <= 1'b0;
`endif
    end else begin
      cmd_done <= 1'b0;
      rd_valid <= 1'b0;
`ifdef SPI_MASTER_SEQ_CHECK_EN
      cmd_err  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          SS_n <= 1'b1;
          MOSI <= 1'b0;
          if (accept) begin
            cmd_ready <= 1'b0;
            if (seq_block) begin
              // Rejected read: SS_n never dropped, so the gap is already satisfied.
`ifdef SPI_MASTER_SEQ_CHECK_EN
              cmd_err <= 1'b1;
`endif
              gap_cnt <= GAP_MIN;
            end else begin
              state  <= START;
              SS_n   <= 1'b0;
              opcode <= cmd_data[CMD_W-1:CMD_W-2];
            end
          end else if (!cmd_ready) begin
            if (gap_met) begin
              cmd_ready <= 1'b1;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
        end

        START: begin
          MOSI  <= sh_bit;
          state <= SEL;
        end

        SEL: begin
          MOSI  <= sh_bit;
          cnt   <= '0;
          state <= SHIFT;
        end

        SHIFT: begin
          if (cnt == SHIFT_LAST) begin
            MOSI  <= 1'b0;
            state <= GUARD;
          end else begin
            MOSI <= sh_bit;
            cnt  <= cnt + 4'd1;
          end
        end

        GUARD: begin
          cnt <= '0;
          if (opcode == OP_RD_DATA) begin
            state <= WAIT_RD;
          end else begin
            state    <= STOP;
            SS_n     <= 1'b1;
            cmd_done <= 1'b1;
            gap_cnt  <= 4'd1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
            if (opcode == OP_RD_ADDR) begin
              rd_addr_seen <= 1'b1;
            end
`endif
          end
        end

        WAIT_RD: begin
          if (cnt == WAIT_LAST) begin
            cnt   <= '0;
            state <= RECV;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        RECV: begin
          if (cnt == RECV_LAST) begin
            state    <= STOP;
            SS_n     <= 1'b1;
            cmd_done <= 1'b1;
            rd_valid <= 1'b1;
            rd_data  <= rx_next;
            gap_cnt  <= 4'd1;
`ifdef SPI_MASTER_SEQ_CHECK_EN
            rd_addr_seen <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 4'd1;
          end
        end

        STOP: begin
          state <= IDLE;
          if (gap_met) begin
            cmd_ready <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// tb/tb_spi_master_ctrl.sv - directed self-checking bench for spi_master_ctrl
module tb_spi_master_ctrl;

  localparam int L = 4;
  localparam int G = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [9:0] cmd_data = '0;
  logic       MISO = 1'b0;
  logic       cmd_ready;
  logic       SS_n;
  logic       MOSI;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       cmd_done;
`ifdef SPI_MASTER_SEQ_CHECK_EN
  logic       cmd_err;
`endif

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  spi_master_ctrl #(.RD_LAT(L), .IDLE_GAP(G)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_data  (cmd_data),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .cmd_done  (cmd_done)
`ifdef SPI_MASTER_SEQ_CHECK_EN
    ,
    .cmd_err   (cmd_err)
`endif
  );

  // Slave + RAM model: counts SS_n-low cycles, decodes the word sent on T3..T12,
  // answers a rd-data with ram[addr] during the receive window, random noise otherwise.
  int         sk = 0;
  logic [9:0] srx = '0;
  logic [7:0] saddr = '0;
  logic [7:0] sbyte = '0;

  always @(negedge clk) begin
    if (SS_n) begin
      sk = 0;
    end else begin
      sk = sk + 1;
      if (sk >= 3 && sk <= 12) srx = {srx[8:0], MOSI};
      if (sk == 13) begin
        if (srx[9:8] == 2'b10) saddr = srx[7:0];
        if (srx[9:8] == 2'b11) sbyte = (saddr == 8'h55) ? 8'hA5 : 8'h00;
      end
    end
    if (!SS_n && sk >= 14 + L && sk <= 21 + L) MISO = sbyte[7 - (sk - 14 - L)];
    else MISO = 1'($urandom);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] ss_v, mosi_v, done_v, rdv_v, rdy_v;
  int          wait_cyc;

  // Called at a negedge; returns at the negedge of the accept cycle T0.
  task automatic offer(input logic [9:0] d);
    cmd_valid = 1'b1;
    cmd_data  = d;
    wait_cyc  = 0;
    while (!cmd_ready && wait_cyc < 50) begin
      @(negedge clk);
      wait_cyc++;
    end
    check("accept_bound", 32'(cmd_ready), 1);
  endtask

  // Records T1..Tn; bit k of each vector is the output seen in cycle Tk.
  task automatic record(input int n, input bit hold, input logic [9:0] d_next);
    ss_v = '0; mosi_v = '0; done_v = '0; rdv_v = '0; rdy_v = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) cmd_data = d_next;
        else cmd_valid = 1'b0;
      end
      ss_v[k]   = SS_n;
      mosi_v[k] = MOSI;
      done_v[k] = cmd_done;
      rdv_v[k]  = rd_valid;
      rdy_v[k]  = cmd_ready;
    end
  endtask

  initial begin
    logic acc;

    repeat (3) @(negedge clk);
    check("rst_ss_n", 32'(SS_n), 1);
    check("rst_mosi", 32'(MOSI), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 0);
    check("rst_rd_valid", 32'(rd_valid), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_cmd_done", 32'(cmd_done), 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_gap_r1", 32'(cmd_ready), 0);
    @(negedge clk);
    check("ready_gap_r2", 32'(cmd_ready), 1);

    // wr-addr 0x0AA
    offer(10'h0AA);
    record(14, 1'b0, 10'h000);
    check("wa_mosi", mosi_v, 32'h0000_0AA0);
    check("wa_ss_n", ss_v, 32'h0000_4000);
    check("wa_done", done_v, 32'h0000_4000);
    check("wa_ready", rdy_v, 32'h0);
    check("wa_rd_valid", rdv_v, 32'h0);

    // wr-data 0x1C3 with cmd_valid held, next word changed mid-frame
    offer(10'h1C3);
    record(14, 1'b1, 10'h155);
    check("wd_mosi", mosi_v, 32'h0000_1870);
    check("wd_ss_n", ss_v, 32'h0000_4000);
    check("wd_done", done_v, 32'h0000_4000);
    check("wd_ready_in_frame", rdy_v, 32'h0);
    offer(10'h155);
    check("b2b_gap", 32'(wait_cyc), G);
    record(14, 1'b0, 10'h000);
    check("b2b_mosi", mosi_v, 32'h0000_1550);
    check("b2b_done", done_v, 32'h0000_4000);
    check("rd_data_still_zero", 32'(rd_data), 0);

    // rd-addr 0x255, then rd-data 0x3FF
    offer(10'h255);
    record(14, 1'b0, 10'h000);
    check("ra_mosi", mosi_v, 32'h0000_154C);
    check("ra_done", done_v, 32'h0000_4000);
    offer(10'h3FF);
    record(14 + L + 8, 1'b0, 10'h000);
    check("rd_mosi", mosi_v, 32'h0000_1FFC);
    check("rd_ss_n", ss_v, 32'h0400_0000);
    check("rd_done", done_v, 32'h0400_0000);
    check("rd_valid_pulse", rdv_v, 32'h0400_0000);
    check("rd_data_val", 32'(rd_data), 32'hA5);
    repeat (3) @(negedge clk);
    check("rd_valid_low", 32'(rd_valid), 0);
    check("rd_data_held", 32'(rd_data), 32'hA5);
    offer(10'h0AA);
    record(14, 1'b0, 10'h000);
    check("rd_data_after_wr", 32'(rd_data), 32'hA5);

    // reset in T7 of a wr-addr frame
    offer(10'h0AA);
    record(7, 1'b0, 10'h000);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ss_n", 32'(SS_n), 1);
    check("midrst_mosi", 32'(MOSI), 0);
    check("midrst_done", 32'(cmd_done), 0);
    check("midrst_ready", 32'(cmd_ready), 0);
    rst = 1'b0;
    acc = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | cmd_done | rd_valid | ~SS_n;
    end
    check("midrst_quiet", 32'(acc), 0);

`ifdef SPI_MASTER_SEQ_CHECK_EN
    offer(10'h300);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("seq_err_t1", 32'(cmd_err), 1);
    check("seq_ss_n_t1", 32'(SS_n), 1);
    acc = 1'b0;
    repeat (4) begin
      @(negedge clk);
      acc = acc | cmd_done | cmd_err | ~SS_n;
    end
    check("seq_quiet", 32'(acc), 0);
`endif

    offer(10'h0AA);
    record(14, 1'b0, 10'h000);
    check("post_rst_mosi", mosi_v, 32'h0000_0AA0);
    check("post_rst_ss_n", ss_v, 32'h0000_4000);
    check("post_rst_done", done_v, 32'h0000_4000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
